icache_refill: RTL
==================

// Module: icache_refill
// PURPOSE
//  Line-refill writer for the I-cache data/tag RAMs. On a miss it issues one AXI4
//  INCR burst read for the 32-byte line and writes each returned word into its
//  data-RAM bank, then writes the tag.
//  Sits between the I-cache control FSM (miss side) and the AXI read channel.
// PARAMETERS
//  LINE_WORDS  8      words per line; one data-RAM bank per word; must be 8 (index = addr[11:5])
//  AXI_ID      4'd0   ARID driven on every burst
//  TAG_W       20     tag width = addr[31:12]
// PORTS
//  clk          in   1            clock
//  rst          in   1            asynchronous reset, active-high
//  miss_req     in   1            level; refill request, sampled only in IDLE
//  miss_addr    in   32           missing fetch address
//  refill_busy  out  1            high in every state except IDLE
//  refill_done  out  1            one-cycle pulse: line and tag written
//  refill_err   out  1            one-cycle pulse with refill_done: bad rresp or short burst
//  arid         out  4            AXI_ID
//  araddr       out  32           {line_addr[31:5],5'b0}
//  arlen        out  8            LINE_WORDS-1
//  arsize       out  3            3'b010
//  arburst      out  2            2'b01 (INCR)
//  arvalid      out  1            AR valid
//  arready      in   1            AR ready
//  rdata        in   32           R data
//  rresp        in   2            R response
//  rlast        in   1            R last
//  rvalid       in   1            R valid
//  rready       out  1            R ready
//  ram_en       out  1            data-RAM enable for the write
//  ram_bank_sel out  LINE_WORDS   one-hot bank select
//  ram_wen      out  4            4'hf when writing, else 4'h0
//  ram_addr     out  32           {line_addr[31:5],5'b0}; bank uses [11:5]
//  ram_wdata    out  32           word to write
//  tag_wen      out  1            tag write strobe
//  tag_wdata    out  TAG_W+1      {valid, line_addr[31:12]}
//  crit_valid   out  1            early-restart word valid (optional feature)
//  crit_data    out  32           early-restart word (optional feature)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, beat_cnt=0, line_addr=0, err=0; all outputs 0.
//  FSM IDLE -> AR -> R -> DONE -> IDLE.
//   IDLE:
//    - miss_req=1: latch line_addr={miss_addr[31:5],5'b0} and word_off=miss_addr[4:2]; go to AR.
//   AR:
//    - arvalid=1; AR fields are constant while arvalid is high.
//    - arvalid&arready: go to R. First R beat is accepted no earlier than the next cycle.
//   R:
//    - rready=1.
//    - Each rvalid beat, same cycle: ram_en=1, ram_wen=4'hf, ram_bank_sel=1<<beat_cnt, ram_wdata=rdata.
//    - beat_cnt increments by 1 per beat.
//    - rresp!=2'b00 on any beat sets err.
//    - rlast before beat LINE_WORDS-1 sets err and ends the burst.
//    - Beat with beat_cnt==LINE_WORDS-1 ends the burst regardless of rlast.
//    - End of burst: go to DONE.
//   DONE (1 cycle):
//    - tag_wen=1, tag_wdata={~err, line_addr[31:12]}.
//    - refill_done=1; refill_err=err.
//    - Clear beat_cnt and err; go to IDLE.
//  Latency: miss_req to arvalid is 1 cycle; last R beat to refill_done is 1 cycle.
//  Back-to-back misses: miss_req held high in the cycle after DONE starts a new refill.
//  rvalid outside R is ignored (rready=0). beat_cnt is 3 bits and never wraps past 7.
//  Reset mid-burst: the AXI side must be reset together; no partial tag is ever written.
// CONFIGURATION
//  ICACHE_REFILL_EARLY_RESTART_EN
//   - Defined: on the R beat with beat_cnt==word_off, register rdata -> crit_data.
//     crit_valid pulses 1 cycle later, once per refill, even when err is set.
//   - Undefined: crit_valid=0 and crit_data=0 constantly. The CPU re-fetches after refill_done.
// TESTING
//  - Miss 0x1FC0_0024, arready=1, 8 beats 0xA0..0xA7 with no gaps
//    -> araddr=0x1FC0_0020, arlen=7; banks 0..7 get A0..A7 at ram_addr[11:5]=7'h01;
//    tag_wdata={1,20'h1FC00}; refill_done 1 cycle after beat 7.
//  - arready held low 5 cycles, rvalid gaps between beats
//    -> AR fields stable throughout; only beats with rvalid write; beat order preserved.
//  - rresp=2'b10 on beat 3 -> all 8 beats written; tag valid bit=0; refill_err and refill_done pulse together.
//  - rlast on beat 5 -> burst ends after beat 5; refill_err=1; tag valid bit=0.
//  - Reset asserted during beat 4 -> all outputs 0 immediately; no tag_wen.
//    Next miss refills from beat 0.
//  - EARLY_RESTART_EN defined, miss_addr[4:2]=3 -> crit_valid pulses 1 cycle after beat 3 with crit_data=0xA3.
//    Undefined -> crit_valid never asserts.

Source files
------------

// File: rtl/icache_refill_if.sv
// AXI4 read-address / read-data channel bundle used by the I-cache line refill
// writer. The refill writer is the master; the memory side is the slave.
interface icache_refill_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/icache_refill.sv
// I-cache line refill writer: on a miss, issues one AXI4 INCR burst for the
// 32-byte line, writes each returned word straight into its data-RAM bank in
// the beat cycle, then writes the tag (valid bit cleared on a bad response or
// a short burst).
// Optional feature macro: ICACHE_REFILL_EARLY_RESTART_EN -- when defined, the
// word the CPU missed on is captured from the burst and presented one cycle
// later on crit_valid/crit_data; when undefined those outputs are tied to 0.
module icache_refill #(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         TAG_W      = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  output logic                  refill_busy,
  output logic                  refill_done,
  output logic                  refill_err,
  icache_refill_if.master       axi,
  output logic                  ram_en,
  output logic [LINE_WORDS-1:0] ram_bank_sel,
  output logic [3:0]            ram_wen,
  output logic [31:0]           ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  tag_wen,
  output logic [TAG_W:0]        tag_wdata,
  output logic                  crit_valid,
  output logic [31:0]           crit_data
);

  localparam int                CNT_W     = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [26:0]      line_r;      // line address bits [31:5]
  logic             err_r;

  logic             beat_s;      // accepted R beat this cycle
  logic             last_idx_s;  // beat counter sits on the final word
  logic             burst_end_s; // this beat closes the burst
  logic             beat_err_s;  // this beat flags the refill as bad
  logic             start_s;     // miss accepted in IDLE

  assign start_s     = (state_r == S_IDLE) && miss_req;
  assign beat_s      = (state_r == S_R) && axi.rvalid;
  assign last_idx_s  = (beat_cnt_r == LAST_BEAT);
  assign burst_end_s = beat_s && (axi.rlast || last_idx_s);
  assign beat_err_s  = beat_s && ((axi.rresp != 2'b00) || (axi.rlast && !last_idx_s));

  // Low address bits only select the critical word (or nothing at all).
  logic unused_s;
  assign unused_s = ^miss_addr[4:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Refill bookkeeping: line address, beat counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_r     <= 27'd0;
      beat_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      if (start_s) begin
        line_r <= miss_addr[31:5];
      end
      if (state_r == S_DONE) begin
        beat_cnt_r <= '0;
        err_r      <= 1'b0;
      end else if (beat_s) begin
        // Counter parks on the last word instead of wrapping.
        beat_cnt_r <= last_idx_s ? beat_cnt_r : beat_cnt_r + CNT_W'(1);
        err_r      <= err_r | beat_err_s;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (miss_req) state_s = S_AR;
        else          state_s = S_IDLE;
      end
      S_AR: begin
        if (axi.arready) state_s = S_R;
        else             state_s = S_AR;
      end
      S_R: begin
        if (burst_end_s) state_s = S_DONE;
        else             state_s = S_R;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode; RAM writes follow rvalid in the same cycle.
  always_comb begin
    refill_busy  = 1'b0;
    refill_done  = 1'b0;
    refill_err   = 1'b0;
    axi.arid     = 4'd0;
    axi.araddr   = 32'd0;
    axi.arlen    = 8'd0;
    axi.arsize   = 3'd0;
    axi.arburst  = 2'd0;
    axi.arvalid  = 1'b0;
    axi.rready   = 1'b0;
    ram_en       = 1'b0;
    ram_bank_sel = '0;
    ram_wen      = 4'h0;
    ram_addr     = {line_r, 5'b0};
    ram_wdata    = 32'd0;
    tag_wen      = 1'b0;
    tag_wdata    = '0;
    case (state_r)
      S_IDLE: begin
        refill_busy = 1'b0;
      end
      S_AR: begin
        refill_busy = 1'b1;
        axi.arvalid = 1'b1;
        axi.arid    = AXI_ID;
        axi.araddr  = {line_r, 5'b0};
        axi.arlen   = 8'(LINE_WORDS - 1);
        axi.arsize  = 3'b010;
        axi.arburst = 2'b01;
      end
      S_R: begin
        refill_busy = 1'b1;
        axi.rready  = 1'b1;
        if (axi.rvalid) begin
          ram_en       = 1'b1;
          ram_wen      = 4'hf;
          ram_bank_sel = {{(LINE_WORDS-1){1'b0}}, 1'b1} << beat_cnt_r;
          ram_wdata    = axi.rdata;
        end else begin
          ram_en       = 1'b0;
        end
      end
      S_DONE: begin
        refill_busy = 1'b1;
        refill_done = 1'b1;
        refill_err  = err_r;
        tag_wen     = 1'b1;
        tag_wdata   = {~err_r, line_r[26 -: TAG_W]};
      end
      default: begin
        refill_busy = 1'b0;
      end
    endcase
  end

`ifdef ICACHE_REFILL_EARLY_RESTART_EN
  logic [CNT_W-1:0] word_off_r;
  logic             crit_valid_r;
  logic [31:0]      crit_data_r;
  logic             crit_hit_s;

  // The beat counter visits each offset at most once, so this fires once per refill.
  assign crit_hit_s = beat_s && (beat_cnt_r == word_off_r);

  // Capture the missed word's offset and, later, the word itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_off_r   <= '0;
      crit_valid_r <= 1'b0;
      crit_data_r  <= 32'd0;
    end else begin
      if (start_s) begin
        word_off_r <= miss_addr[2 +: CNT_W];
      end
      crit_valid_r <= crit_hit_s;
      if (crit_hit_s) begin
        crit_data_r <= axi.rdata;
      end
    end
  end

  assign crit_valid = crit_valid_r;
  assign crit_data  = crit_data_r;
`else
  assign crit_valid = 1'b0;
  assign crit_data  = 32'd0;
`endif

endmodule
